// File: rtl/cache_fill_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cache_fill_fsm
//  Description : Miss-handling controller sitting between the cache arrays and
//                a multi-cycle, pipelined word memory. On a miss it fetches the
//                whole aligned block holding the miss address:
//                  - one memory read request per cycle, back to back;
//                  - each returned word is written into the cache data array;
//                  - the tag/valid entry is written when the last word lands.
//                The core stalls while fsm_busy is high.
//
//  Ports
//    clk             in   1           clock, all state updates on rising edge
//    rst_n           in   1           synchronous active-low reset
//    miss_detected   in   1           lookup missed this cycle (sampled in IDLE)
//    miss_address    in   ADDR_WIDTH  byte address of the missing access
//    fsm_busy        out  1           fill in progress
//    mem_req         out  1           memory read-request strobe
//    mem_addr        out  ADDR_WIDTH  byte address of the current request
//    mem_data_valid  in   1           memory returns one word (request order)
//    mem_data        in   16          returned word
//    cache_wr_en     out  1           data-array write strobe
//    cache_wr_addr   out  ADDR_WIDTH  byte address of the word being written
//    cache_wr_data   out  16          mem_data passed straight through
//    tag_wr_en       out  1           tag/valid write pulse (last word)
//    fill_done       out  1           fill complete pulse (same as tag_wr_en)
//
//  Revision    : 1.0  initial release
// ============================================================================
module cache_fill_fsm #(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    output logic                  fsm_busy,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_data_valid,
    input  logic [15:0]           mem_data,
    output logic                  cache_wr_en,
    output logic [ADDR_WIDTH-1:0] cache_wr_addr,
    output logic [15:0]           cache_wr_data,
    output logic                  tag_wr_en,
    output logic                  fill_done
);

    // Word index width inside a block, byte-offset width, counter width.
    localparam int IDXW = $clog2(WORDS_PER_BLOCK);
    localparam int OFFB = IDXW + 1;
    localparam int CNTW = IDXW + 1;

    localparam logic [CNTW-1:0]       c_full      = CNTW'(WORDS_PER_BLOCK);
    localparam logic [CNTW-1:0]       c_last      = CNTW'(WORDS_PER_BLOCK - 1);
    localparam logic [ADDR_WIDTH-1:0] c_base_mask = ~(ADDR_WIDTH'((1 << OFFB) - 1));

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] w_base_nxt;
    logic [CNTW-1:0]       r_issue_cnt;
    logic [CNTW-1:0]       w_issue_nxt;
    logic [CNTW-1:0]       r_recv_cnt;
    logic [CNTW-1:0]       w_recv_nxt;

    logic                  w_fill;
    logic                  w_mem_req;
    logic                  w_wr_en;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_issue_off;
    logic [ADDR_WIDTH-1:0] w_recv_off;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_base      <= w_base_nxt;
            r_issue_cnt <= w_issue_nxt;
            r_recv_cnt  <= w_recv_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_base_nxt  = r_base;
        w_issue_nxt = r_issue_cnt;
        w_recv_nxt  = r_recv_cnt;

        w_fill    = (r_state == ST_FILL);
        w_mem_req = w_fill && (r_issue_cnt < c_full);
        w_wr_en   = w_fill && mem_data_valid && (r_recv_cnt < c_full);
        w_last    = w_wr_en && (r_recv_cnt == c_last);

        // Offsets only ever reach 2*(WORDS_PER_BLOCK-1), which fits the
        // cleared low bits of the base, so OR-ing is a carry-free add and the
        // address can never spill into the tag bits (0xFFF0 -> 0xFFFE max).
        w_issue_off = ADDR_WIDTH'({r_issue_cnt[IDXW-1:0], 1'b0});
        w_recv_off  = ADDR_WIDTH'({r_recv_cnt[IDXW-1:0], 1'b0});

        case (r_state)
            ST_IDLE: begin
                if (miss_detected) begin
                    w_state_nxt = ST_FILL;
                    w_base_nxt  = miss_address & c_base_mask;
                    w_issue_nxt = '0;
                    w_recv_nxt  = '0;
                end
            end
            ST_FILL: begin
                // A further miss here is deliberately ignored: the base of
                // the block in flight must not move.
                if (w_mem_req) begin
                    w_issue_nxt = r_issue_cnt + 1'b1;
                end
                if (w_wr_en) begin
                    w_recv_nxt = r_recv_cnt + 1'b1;
                end
                // Counters are cleared on exit so that IDLE always presents
                // clean zero counts; the next miss reloads them anyway.
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                    w_issue_nxt = '0;
                    w_recv_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        fsm_busy      = w_fill;
        mem_req       = w_mem_req;
        mem_addr      = w_mem_req ? (r_base | w_issue_off) : '0;
        cache_wr_en   = w_wr_en;
        cache_wr_addr = r_base | w_recv_off;
        cache_wr_data = mem_data;
        tag_wr_en     = w_last;
        fill_done     = w_last;
    end

endmodule
`default_nettype wire
